// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Optional performance counters are enabled by defining BRANCH_PRED_PERF_EN.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        br_pred,
  output logic [31:0] new_pc_pred,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred
`ifdef BRANCH_PRED_PERF_EN
  ,
  output logic [31:0] perf_upd_cnt,
  output logic [31:0] perf_mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [29:0]        target_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  assign rd_idx  = pc[IDX_W+1:2];
  assign rd_tag  = pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    br_pred     = rd_hit && ctr_q[rd_idx][1];
    new_pc_pred = pc + 32'd4;
    if (rd_hit) begin
      new_pc_pred = {target_q[rd_idx], 2'b00};
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
          end
          target_d[upd_idx] = upd_target[31:2];
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Only taken branches earn an entry; allocation starts weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target[31:2];
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      ctr_q    <= ctr_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] perf_upd_q, perf_upd_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  always_comb begin
    perf_upd_d     = perf_upd_q;
    perf_mispred_d = perf_mispred_q;
    if (upd_valid) begin
      perf_upd_d = perf_upd_q + 32'd1;
      if (upd_mispred) begin
        perf_mispred_d = perf_mispred_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_upd_q     <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_upd_q     <= perf_upd_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_upd_cnt     = perf_upd_q;
  assign perf_mispred_cnt = perf_mispred_q;

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_pc[1:0], upd_target[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_pc[1:0], upd_target[1:0], upd_mispred};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16).
// Perf-counter checks compile in only when BRANCH_PRED_PERF_EN is defined.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        br_pred;
  logic [31:0] new_pc_pred;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] perf_upd_cnt;
  logic [31:0] perf_mispred_cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] pc;
    logic        ebr;
    logic [31:0] enpc;
  } vec_t;

  vec_t vecs[$];

  branch_predictor #(.ENTRIES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .br_pred     (br_pred),
    .new_pc_pred (new_pc_pred),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred)
`ifdef BRANCH_PRED_PERF_EN
    ,
    .perf_upd_cnt     (perf_upd_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: drive update + pc, check lookup before the edge, then the edge commits the update.
  function automatic void addVec(input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic [31:0] p,
                                 input logic ebr, input logic [31:0] enpc);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.pc = p; v.ebr = ebr; v.enpc = enpc;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rst, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic mp,
                               input logic [31:0] p);
    @(negedge clk);
    reset       = rst;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    upd_mispred = mp;
    pc          = p;
    #1;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic ebr, input logic [31:0] enpc);
    checkBit({name, ".br_pred"}, br_pred, ebr);
    checkWord({name, ".new_pc_pred"}, new_pc_pred, enpc);
  endtask

  initial begin
    // Reset-state lookups and pc+4 wrap
    addVec(0, 32'h0, 0, 32'h0, 32'h0000_0100, 0, 32'h0000_0104);
    addVec(0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0000_0000);
    // Allocate 0x100 -> 0x200; same-cycle lookup still misses
    addVec(1, 32'h100, 1, 32'h200, 32'h100, 0, 32'h104);
    addVec(0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h200);
    // Decrement to 00 and saturate there; target retained
    addVec(1, 32'h100, 0, 32'h0, 32'h100, 1, 32'h200);
    addVec(1, 32'h100, 0, 32'h0, 32'h100, 0, 32'h200);
    addVec(0, 32'h0,   0, 32'h0, 32'h100, 0, 32'h200);
    addVec(1, 32'h100, 0, 32'h0, 32'h100, 0, 32'h200);
    // Four taken updates: 00 -> 01 -> 10 -> 11 -> 11
    addVec(1, 32'h100, 1, 32'h200, 32'h100, 0, 32'h200);
    addVec(1, 32'h100, 1, 32'h200, 32'h100, 0, 32'h200);
    addVec(1, 32'h100, 1, 32'h200, 32'h100, 1, 32'h200);
    addVec(1, 32'h100, 1, 32'h200, 32'h100, 1, 32'h200);
    // One not-taken from 11 leaves it predicting taken
    addVec(1, 32'h100, 0, 32'h0, 32'h100, 1, 32'h200);
    addVec(0, 32'h0,   0, 32'h0, 32'h100, 1, 32'h200);
    // Taken hit retargets; not-taken hit keeps target
    addVec(1, 32'h100, 1, 32'h280,  32'h100, 1, 32'h200);
    addVec(0, 32'h0,   0, 32'h0,    32'h100, 1, 32'h280);
    addVec(1, 32'h100, 0, 32'h999C, 32'h100, 1, 32'h280);
    addVec(0, 32'h0,   0, 32'h0,    32'h100, 1, 32'h280);
    // Alias 0x140 on index 0 replaces 0x100
    addVec(0, 32'h0,   0, 32'h0,   32'h140, 0, 32'h144);
    addVec(1, 32'h140, 1, 32'h300, 32'h140, 0, 32'h144);
    addVec(0, 32'h0,   0, 32'h0,   32'h140, 1, 32'h300);
    addVec(0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104);
    // Not-taken miss never allocates or disturbs the resident entry
    addVec(1, 32'h1C0, 0, 32'h500, 32'h1C0, 0, 32'h1C4);
    addVec(0, 32'h0,   0, 32'h0,   32'h1C0, 0, 32'h1C4);
    addVec(0, 32'h0,   0, 32'h0,   32'h140, 1, 32'h300);
    // Same-cycle update and lookup at 0x180: no bypass
    addVec(1, 32'h180, 1, 32'h400, 32'h180, 0, 32'h184);
    addVec(0, 32'h0,   0, 32'h0,   32'h180, 1, 32'h400);
    // Second index is independent; low pc bits ignored
    addVec(1, 32'h104, 1, 32'h600, 32'h104, 0, 32'h108);
    addVec(0, 32'h0,   0, 32'h0,   32'h104, 1, 32'h600);
    addVec(0, 32'h0,   0, 32'h0,   32'h180, 1, 32'h400);
    addVec(0, 32'h0,   0, 32'h0,   32'h107, 1, 32'h600);

    reset = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispred = 1'b0; pc = '0;
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, 1'b0, vecs[i].pc);
      checkOutput($sformatf("vec%0d", i), vecs[i].ebr, vecs[i].enpc);
    end

    // Mid-operation reset with a taken update in the reset cycle: update dropped, state cleared
    applyStimulus(1, 1, 32'h100, 1, 32'h200, 1, 32'h100);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h100);
    checkOutput("rst.pc100", 1'b0, 32'h104);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h104);
    checkOutput("rst.pc104", 1'b0, 32'h108);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h180);
    checkOutput("rst.pc180", 1'b0, 32'h184);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h140);
    checkOutput("rst.pc140", 1'b0, 32'h144);

    // After reset, a fresh allocation starts at 10 (one not-taken drops it to 01)
    applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 32'h100);
    applyStimulus(0, 1, 32'h100, 0, 32'h0,   0, 32'h100);
    checkOutput("realloc.ctr10", 1'b1, 32'h200);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h100);
    checkOutput("realloc.ctr01", 1'b0, 32'h200);

`ifdef BRANCH_PRED_PERF_EN
    applyStimulus(1, 1, 32'h100, 1, 32'h200, 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkWord("perf.upd_after_reset", perf_upd_cnt, 32'd0);
    checkWord("perf.mis_after_reset", perf_mispred_cnt, 32'd0);
    applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    applyStimulus(0, 1, 32'h100, 0, 32'h0,   1, 32'h0);
    applyStimulus(0, 0, 32'h100, 1, 32'h0,   1, 32'h0);
    applyStimulus(0, 1, 32'h104, 0, 32'h0,   0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkWord("perf.upd_cnt", perf_upd_cnt, 32'd3);
    checkWord("perf.mispred_cnt", perf_mispred_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor that directly feeds the program counter register's br_pred / new_pc_pred inputs.
- Direct-mapped branch target buffer (BTB): each entry holds valid, tag, target and a 2-bit saturating counter.
- Lookup is combinational on the current fetch PC; the PC register consumes the result on the next clock edge.
- Trained by the execute stage through a single update port when a branch or jump resolves.

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES): index width (derived, localparam).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  current fetch PC (word aligned).
- br_pred  output  1  predict taken for pc.
- new_pc_pred  output  32  predicted next PC.
- upd_valid  input  1  resolved control-flow instruction this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual outcome: 1 = taken.
- upd_target  input  32  actual target address (word aligned).
- upd_mispred  input  1  the resolved prediction was wrong (same signal that drives miss_pred); used only by the optional feature.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; target is stored as bits [31:2]; bits [1:0] are ignored on every input.
- Lookup (combinational, zero latency):
  - hit = entry[index].valid AND tag match.
  - br_pred = hit AND ctr[1].
  - new_pc_pred = target (with 2'b00 appended) on hit, otherwise pc+4 (wraps modulo 2^32).
  - On a hit with br_pred=0, new_pc_pred still equals the stored target.
- Counter encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- Update, applied at the rising edge when upd_valid=1, using upd_pc's index and tag:
  - Hit, upd_taken=1: ctr saturating +1 (stays at 11); target <= upd_target.
  - Hit, upd_taken=0: ctr saturating -1 (stays at 00); target unchanged.
  - Miss, upd_taken=1: allocate or replace the entry: valid=1, tag, target=upd_target, ctr=10.
  - Miss, upd_taken=0: no change; never-taken branches are not allocated.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update state; the new state is visible from the next cycle. There is no bypass.
- No stall input: lookup is purely combinational, so a stalled PC simply re-reads the same entry. Updates proceed regardless of stall.
- Reset:
  - While reset=1 at an edge: every valid bit cleared, every ctr set to 01, tags and targets unchanged (don't-care).
  - reset dominates upd_valid: an update in the reset cycle is dropped.
  - Outputs after reset: br_pred=0, new_pc_pred=pc+4.
  - A reset in mid-operation discards all learned state within one cycle.
- All storage is flops, so the array is directly visible in the VCD.

Optional Feature:
- Macro: BRANCH_PRED_PERF_EN.
- Defined:
  - Adds outputs perf_upd_cnt [31:0] and perf_mispred_cnt [31:0].
  - perf_upd_cnt increments on every edge with upd_valid=1.
  - perf_mispred_cnt increments when upd_valid=1 and upd_mispred=1.
  - Both cleared to 0 by reset; both wrap from 0xFFFFFFFF to 0; no increment in the reset cycle.
- Undefined: these ports and counters do not exist; upd_mispred is unused.

Test Plan:
- Reset, then pc=0x100 -> br_pred=0, new_pc_pred=0x104; pc=0xFFFFFFFC -> new_pc_pred=0x00000000.
- Update upd_pc=0x100, taken, target=0x200; next cycle pc=0x100 -> br_pred=1, new_pc_pred=0x200 (ctr=10).
- Counter saturation at 0x100 (starting from ctr=10):
  - 2 not-taken updates -> br_pred=0, new_pc_pred=0x200.
  - Then 4 taken -> br_pred=1.
  - Then 1 not-taken -> br_pred=1 (ctr 11 -> 10).
- Alias (ENTRIES=16): with 0x100 trained, pc=0x140 -> br_pred=0, new_pc_pred=0x144. Taken update at 0x140 with target 0x300 replaces the entry; then pc=0x100 -> br_pred=0, new_pc_pred=0x104.
- Same-cycle update and lookup at fresh pc=0x180, taken, target 0x400 -> that cycle br_pred=0; next cycle br_pred=1, new_pc_pred=0x400.
- Reset held one cycle with upd_valid=1 (0x100, taken) -> afterwards all lookups miss. With BRANCH_PRED_PERF_EN: perf counters read 0; then 3 updates (1 with upd_mispred=1) -> perf_upd_cnt=3, perf_mispred_cnt=1.
